// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory target for the MEM stage: one load/store in flight,
// ready held low for LATENCY cycles, registered load data.
module data_mem_responder #(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 3,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] Address,
  input  logic [31:0] ST_val,
  output logic [31:0] MEM_read_value,
  output logic        ready,
  output logic        addr_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic          oor;
    logic [IW-1:0] idx;
    logic [31:0]   data;
  } req_t;

  state_t        state;
  logic [CW-1:0] cnt;
  req_t          lreq, in_req, c_req;
  logic [31:0]   offset;
  logic          req, commit;
  logic [31:0]   mem [DEPTH];

  // A store wins when both enables are high, so rd is only a pure load.
  always_comb begin
    offset      = Address - BASE_ADDR;
    in_req.wr   = MEM_W_EN;
    in_req.rd   = MEM_R_EN & ~MEM_W_EN;
    in_req.oor  = (Address < BASE_ADDR) || (offset[31:2] >= 30'(DEPTH));
    in_req.idx  = offset[IW+1:2];
    in_req.data = ST_val;
  end

  assign req   = MEM_R_EN | MEM_W_EN;
  assign ready = (state == DONE) || (state == IDLE && !req);

  // With LATENCY 1 the commit happens on the accepting edge, before anything is latched.
  assign c_req  = (state == IDLE) ? in_req : lreq;
  assign commit = (state == IDLE && req && LATENCY == 1) ||
                  (state == BUSY && cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      lreq           <= '0;
      MEM_read_value <= '0;
      addr_err       <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          lreq <= in_req;
          if (LATENCY == 1) state <= DONE;
          else begin
            state <= BUSY;
            cnt   <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
          end
        end
        BUSY: if (cnt == '0) state <= DONE;
              else           cnt   <= cnt - 1'b1;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        addr_err <= c_req.oor;
        if (c_req.rd) MEM_read_value <= c_req.oor ? '0 : mem[c_req.idx];
      end
    end
  end

  // Array is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_req.wr && !c_req.oor)
      mem[c_req.idx] <= c_req.data;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: LATENCY=3 and LATENCY=1 instances, directed vectors with
// hand-computed expected read data / addr_err / stall length per request.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       r_en, w_en, rdy, aerr;
  logic [1:0][31:0] addr, stv, rdv;

  data_mem_responder #(.DEPTH(64), .LATENCY(3), .BASE_ADDR(32'd1024)) u_lat3 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
    .Address(addr[0]), .ST_val(stv[0]), .MEM_read_value(rdv[0]),
    .ready(rdy[0]), .addr_err(aerr[0]));

  data_mem_responder #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(32'd1024)) u_lat1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
    .Address(addr[1]), .ST_val(stv[1]), .MEM_read_value(rdv[1]),
    .ready(rdy[1]), .addr_err(aerr[1]));

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   low_cnt [2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a request completes when ready returns high after a low run.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst) low_cnt[k] = 0;
      else if (!rdy[k]) begin
        low_cnt[k]++;
        chk($sformatf("addr_err_stall_dut%0d", k), {31'b0, aerr[k]}, 32'd0);
      end else if (low_cnt[k] != 0) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_completion dut%0d: got extra commit expected none", k);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk({e.name, "_latency"}, 32'(low_cnt[k]), (k == 0) ? 32'd3 : 32'd1);
          chk({e.name, "_rdata"}, rdv[k], e.rd);
          chk({e.name, "_addr_err"}, {31'b0, aerr[k]}, {31'b0, e.err});
        end
        low_cnt[k] = 0;
      end else begin
        chk($sformatf("addr_err_idle_dut%0d", k), {31'b0, aerr[k]}, 32'd0);
      end
    end
  end

  // Drive one request, push its expectation, wait for its DONE cycle.
  task automatic issue(int k, bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                       logic [31:0] exp_rd, bit exp_err, string nm, bit hold = 1'b0);
    exp_t e;
    bit   seen_low, done;
    e.rd = exp_rd; e.err = exp_err; e.name = nm;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    r_en[k] = rd; w_en[k] = wr; addr[k] = a; stv[k] = d;
    seen_low = 1'b0;
    done     = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (seen_low && rdy[k]) done = 1'b1;
      if (!rdy[k]) seen_low = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no DONE expected DONE within 20 cycles", nm);
    end
    if (!hold) begin
      @(posedge clk); #1;
      r_en[k] = 1'b0; w_en[k] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    r_en = '0; w_en = '0; addr = '0; stv = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_rdata_dut%0d", k), rdv[k], 32'd0);
      chk($sformatf("reset_ready_dut%0d", k), {31'b0, rdy[k]}, 32'd1);
      chk($sformatf("reset_err_dut%0d", k), {31'b0, aerr[k]}, 32'd0);
    end
    @(posedge clk); #1;

    // Single-cycle build
    issue(1, 0, 1, 32'd1024, 32'h11, 32'h0,  1'b0, "l1_st_1024");
    issue(1, 1, 0, 32'd1024, 32'h0,  32'h11, 1'b0, "l1_ld_1024");

    // Out-of-range loads, then basic store/load
    issue(0, 1, 0, 32'd1280, 32'h0, 32'h0, 1'b1, "ld_1280_oor");
    issue(0, 1, 0, 32'd1020, 32'h0, 32'h0, 1'b1, "ld_1020_oor");
    issue(0, 0, 1, 32'd1028, 32'hDEADBEEF, 32'h0,        1'b0, "st_1028");
    issue(0, 1, 0, 32'd1028, 32'h0,        32'hDEADBEEF, 1'b0, "ld_1028");
    issue(0, 1, 0, 32'd1030, 32'h0,        32'hDEADBEEF, 1'b0, "ld_1030_unaligned");

    // Dropped out-of-range store must not alias onto word 0
    issue(0, 0, 1, 32'd1024, 32'h1234, 32'hDEADBEEF, 1'b0, "st_1024");
    issue(0, 0, 1, 32'd1280, 32'h33,   32'hDEADBEEF, 1'b1, "st_1280_oor");
    issue(0, 1, 0, 32'd1024, 32'h0,    32'h1234,     1'b0, "ld_1024");
    issue(0, 0, 1, 32'd1276, 32'hC3,   32'h1234,     1'b0, "st_1276_last");
    issue(0, 1, 0, 32'd1276, 32'h0,    32'hC3,       1'b0, "ld_1276_last");

    // Reset in the second BUSY cycle aborts the in-flight store
    issue(0, 0, 1, 32'd1032, 32'h5, 32'hC3, 1'b0, "st_1032_5");
    w_en[0] = 1'b1; addr[0] = 32'd1032; stv[0] = 32'h9;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; w_en[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_rdata_dut%0d", k), rdv[k], 32'd0);
      chk($sformatf("midrst_ready_dut%0d", k), {31'b0, rdy[k]}, 32'd1);
      chk($sformatf("midrst_err_dut%0d", k), {31'b0, aerr[k]}, 32'd0);
    end
    @(posedge clk); #1;
    issue(0, 1, 0, 32'd1032, 32'h0, 32'h5, 1'b0, "ld_1032_after_abort");

    // Enables held high across two back-to-back loads
    issue(0, 0, 1, 32'd1036, 32'hA1, 32'h5, 1'b0, "st_1036");
    issue(0, 0, 1, 32'd1040, 32'hB2, 32'h5, 1'b0, "st_1040");
    issue(0, 1, 0, 32'd1036, 32'h0, 32'hA1, 1'b0, "held_ld_1036", 1'b1);
    issue(0, 1, 0, 32'd1040, 32'h0, 32'hB2, 1'b0, "held_ld_1040");

    // Both enables: store only, read data untouched
    issue(0, 1, 1, 32'd1044, 32'h77, 32'hB2, 1'b0, "both_1044");
    issue(0, 1, 0, 32'd1044, 32'h0,  32'h77, 1'b0, "ld_1044");

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
